spi_ram_responder: RTL and testbench
====================================

// Module: spi_ram_responder
// PURPOSE
//   Synthesizable SPI-mode-0 memory target: the responder end of the CPU's SPI instruction-fetch bus.
//   Serves READ (0x03) with an 8-bit address and auto-increment, plus optional WRITE (0x02).
//   Oversamples SCK/CS_N/MOSI in the system clock domain. Sits beside the CPU top for on-chip/FPGA demos.
//   Also replaces the behavioural RAM model in benches.
// PARAMETERS
//   MEM_BYTES  256  memory depth in bytes; must equal 2**ADDR_W
//   ADDR_W     8    address width; one address byte on the wire
// PORTS
//   clk         in   1       system clock
//   rst         in   1       synchronous, active-high reset
//   spi_cs_n    in   1       chip select, active low, asynchronous to clk
//   spi_sck     in   1       SPI clock, idles low (mode 0)
//   spi_mosi    in   1       serial data from initiator, MSB first
//   spi_miso    out  1       serial data to initiator, MSB first
//   spi_miso_oe out  1       high while driving read data
//   ld_we       in   1       backdoor preload write strobe
//   ld_addr     in   ADDR_W  backdoor write address
//   ld_wdata    in   8       backdoor write data
//   busy        out  1       high while the synchronized CS_N is asserted
// BEHAVIOUR
//   - Reset: spi_miso=0, spi_miso_oe=0, busy=0, FSM=IDLE, bit counter=0, addr=0. Memory contents are not cleared.
//   - Input synchronization: each SPI input uses a 2-flop synchronizer, then an edge detector on clk.
//     - Requirement: SCK high and low phases each >=4 clk cycles.
//     - Response latency from a raw pin edge is 3 clk cycles.
//   - Bit timing: MOSI is sampled on the detected SCK rise; MISO updates on the detected SCK fall.
//   - FSM states and transitions:
//     - IDLE -> CMD on CS_N fall.
//     - CMD: shift in 8 bits, then
//       - 0x03 -> ADDR(rd)
//       - 0x02 -> ADDR(wr), only when write is enabled
//       - any other opcode -> IGNORE
//     - ADDR: shift in 8 bits into addr. Then go to READ or WRITE.
//       - READ entry: on the SCK fall after address bit 0, load shreg=mem[addr], drive bit7, raise spi_miso_oe.
//     - READ:
//       - Each SCK fall shifts out the next bit.
//       - After 8 bits, on that same fall: addr<=addr+1 (wraps 0xFF->0x00), reload shreg, drive the new bit7.
//     - WRITE: after each 8th sampled bit, mem[addr]<=byte, then addr<=addr+1 (wraps).
//     - IGNORE: remain until CS_N rise; MISO held 0 and oe=0.
//   - CS_N rise (synchronized) in any state:
//     - Next clk: FSM=IDLE, oe=0, miso=0, bit counter=0.
//     - A partially received byte is discarded and never written.
//   - Reset asserted mid-transaction: reset values apply at the next clk. The transaction is abandoned; the initiator must re-select.
//   - Backdoor port: ld_we honoured only when busy=0; mem[ld_addr]<=ld_wdata on that clk.
//     - ld_we with busy=1 is dropped silently.
//     - The SPI path can never write concurrently with it.
//   - SCK edges while CS_N is high are ignored.
// CONFIGURATION
//   SPI_RAM_WRITE_EN defined:
//     - Opcode 0x02 is accepted; the WRITE path and its memory write port are built.
//   SPI_RAM_WRITE_EN undefined:
//     - 0x02 is treated as an unknown opcode (IGNORE).
//     - Memory is writable only through the backdoor port.
// STRUCTURE
//   Package spi_ram_pkg:
//     - OPC_READ=8'h03, OPC_WRITE=8'h02
//     - state enum {IDLE,CMD,ADDR,READ,WRITE,IGNORE}
//   Sub-module spi_pin_sync: 2-flop synchronizer plus rise/fall pulse generator, one instance per SPI input.
//   Top contains: FSM, 3-bit bit counter, 8-bit shift registers, address counter, memory array.
// TESTING
//   1. Preload and read:
//      - Stimulus: backdoor-load 0x00..0x03 = 10,64,68,53; READ 0x03, addr 0x00, clock 4 bytes.
//      - Required: MISO returns 0x10,0x64,0x68,0x53.
//   2. Address wrap:
//      - Stimulus: mem[FF]=0xAA, mem[00]=0x10; READ from 0xFF, 2 bytes.
//      - Required: MISO returns 0xAA then 0x10.
//   3. Write then read (SPI_RAM_WRITE_EN):
//      - Stimulus: WRITE 0x02, addr 0x20, data A5,5A; deselect; READ 0x20, 2 bytes.
//      - Required: A5,5A.
//      - Without the macro: the original contents come back.
//   4. Partial byte and unknown opcode:
//      - Stimulus: WRITE at 0x30, CS_N rises after 5 data bits.
//      - Required: mem[0x30] unchanged.
//      - Stimulus: opcode 0x9F plus 16 clocks.
//      - Required: oe=0, MISO=0 throughout.
//   5. Backdoor collision: ld_we pulsed while busy=1 -> memory unchanged; the same pulse with busy=0 -> written.
//   6. Reset mid-READ: rst high for 1 clk during byte 2 -> next clk oe=0, miso=0, busy=0; the next READ works normally.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - opcodes and FSM state type for the SPI RAM responder
package spi_ram_pkg;

    localparam logic [7:0] OPC_READ  = 8'h03;
    localparam logic [7:0] OPC_WRITE = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        READ,
        WRITE,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - 2-flop synchronizer with rise/fall pulses for one SPI pin
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;

    // two metastability stages plus one history stage for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {3{RST_VAL}};
        end else begin
            sync_q <= {sync_q[1:0], pin};
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_ram_responder.sv
// rtl/spi_ram_responder.sv - SPI mode-0 RAM target (READ 0x03, WRITE 0x02 when SPI_RAM_WRITE_EN is defined)
module spi_ram_responder
    import spi_ram_pkg::*;
#(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs_n,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_wdata,
    output logic              busy
);

`ifdef SPI_RAM_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg_in;
    logic [7:0]        shreg_out;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        mem [MEM_BYTES];
    logic              armed;
    logic              is_wr;

    logic cs_lvl, cs_rise, cs_fall;
    logic sck_lvl, sck_rise, sck_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_pins;

    logic       byte_done;
    logic [7:0] byte_val;
    logic       spi_wr;

    // CS sync resets to "selected" so a select held across reset never looks like a fresh
    // falling edge: the initiator has to deselect (arming us) and select again.
    spi_pin_sync #(.RST_VAL(1'b0)) u_cs_sync (
        .clk(clk), .rst(rst), .pin(spi_cs_n), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_pin_sync #(.RST_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rst(rst), .pin(spi_sck), .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );
    spi_pin_sync #(.RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .pin(spi_mosi), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_pins = ^{sck_lvl, mosi_rise, mosi_fall};

    assign busy      = armed & ~cs_lvl;
    assign byte_val  = {shreg_in[6:0], mosi_lvl};
    assign byte_done = sck_rise && (bit_cnt == 3'd7) && !cs_lvl;
    assign rd_addr   = spi_miso_oe ? addr + ADDR_W'(1) : addr;

`ifdef SPI_RAM_WRITE_EN
    assign spi_wr = (state_q == WRITE) && byte_done;
`else
    assign spi_wr = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state: deselect always wins and returns to IDLE
    always_comb begin
        state_d = state_q;
        if (cs_lvl) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall && armed) state_d = CMD;
                end
                CMD: begin
                    if (byte_done) begin
                        if (byte_val == OPC_READ)               state_d = ADDR;
                        else if (WR_EN && byte_val == OPC_WRITE) state_d = ADDR;
                        else                                     state_d = IGNORE;
                    end
                end
                ADDR: begin
                    if (byte_done) state_d = is_wr ? WRITE : READ;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // bit counter, shift registers, address counter and MISO drive
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= 3'd0;
            shreg_in    <= 8'd0;
            shreg_out   <= 8'd0;
            addr        <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            armed       <= 1'b0;
            is_wr       <= 1'b0;
        end else begin
            if (cs_rise) armed <= 1'b1;
            if (cs_lvl || state_q == IDLE) begin
                bit_cnt     <= 3'd0;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
            end else begin
                case (state_q)
                    CMD, ADDR, WRITE: begin
                        if (sck_rise) begin
                            shreg_in <= byte_val;
                            bit_cnt  <= bit_cnt + 3'd1;
                        end
                    end
                    READ: begin
                        if (sck_fall) begin
                            // first fall after the address, or 8 bits already shifted: fetch a byte
                            if (!spi_miso_oe || bit_cnt == 3'd0) begin
                                shreg_out   <= mem[rd_addr];
                                spi_miso    <= mem[rd_addr][7];
                                addr        <= rd_addr;
                                bit_cnt     <= 3'd1;
                                spi_miso_oe <= 1'b1;
                            end else begin
                                spi_miso  <= shreg_out[6];
                                shreg_out <= {shreg_out[6:0], 1'b0};
                                bit_cnt   <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    default: ;
                endcase
                if (state_q == CMD && byte_done) is_wr <= WR_EN && (byte_val == OPC_WRITE);
                if (state_q == ADDR && byte_done) addr <= byte_val[ADDR_W-1:0];
                if (spi_wr) addr <= addr + ADDR_W'(1);
            end
        end
    end

    // memory write port: backdoor only while idle; SPI writes only happen while busy
    always_ff @(posedge clk) begin
        if (ld_we && !busy) begin
            mem[ld_addr] <= ld_wdata;
        end else if (spi_wr) begin
            mem[addr] <= byte_val;
        end
    end

endmodule

// File: tb/tb_spi_ram_responder.sv
// tb/tb_spi_ram_responder.sv - self-checking bench for spi_ram_responder
module tb_spi_ram_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_cs_n;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       ld_we;
    logic [7:0] ld_addr;
    logic [7:0] ld_wdata;
    logic       busy;

    spi_ram_responder #(.MEM_BYTES(256), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  start;
        int          n;
        logic [31:0] exp;
    } rd_vec_t;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] ref_mem [256];
    logic       selected = 1'b0;
    logic       drive_seen;
    logic [7:0] rd_buf [4];
    logic [7:0] wr_buf [4];
    rd_vec_t    vecs [3];

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive_seen = drive_seen | spi_miso_oe | spi_miso;
        end
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = a; ld_wdata = d;
        @(negedge clk);
        ld_we = 1'b0;
        if (!selected) ref_mem[a] = d;
    endtask

    task automatic spi_select();
        @(negedge clk);
        spi_cs_n = 1'b0;
        selected = 1'b1;
        wait_clks(6);
    endtask

    task automatic spi_deselect();
        wait_clks(6);
        spi_cs_n = 1'b1;
        selected = 1'b0;
        wait_clks(8);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_mosi = tx[7-i];
            wait_clks(6);
            rx = {rx[6:0], spi_miso};
            spi_sck = 1'b1;
            wait_clks(6);
            spi_sck = 1'b0;
        end
    endtask

    task automatic spi_read(input logic [7:0] a, input int n);
        logic [7:0] rx;
        spi_select();
        spi_bits(8'h03, 8, rx);
        spi_bits(a, 8, rx);
        for (int i = 0; i < n; i++) begin
            spi_bits(8'h00, 8, rx);
            rd_buf[i] = rx;
        end
        spi_deselect();
    endtask

    task automatic spi_write(input logic [7:0] a, input int n);
        logic [7:0] rx;
        spi_select();
        spi_bits(8'h02, 8, rx);
        spi_bits(a, 8, rx);
        for (int i = 0; i < n; i++) begin
            spi_bits(wr_buf[i], 8, rx);
`ifdef SPI_RAM_WRITE_EN
            ref_mem[8'(a + i)] = wr_buf[i];
`endif
        end
        spi_deselect();
    endtask

    initial begin
        logic [7:0]  rx;
        logic [31:0] e;
        logic [7:0]  a;
        int          n;

        vecs[0] = '{start: 8'h00, n: 4, exp: 32'h10646853};
        vecs[1] = '{start: 8'hFF, n: 2, exp: 32'hAA100000};
        vecs[2] = '{start: 8'h02, n: 2, exp: 32'h68530000};

        drive_seen = 1'b0;
        rst = 1'b1; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        ld_we = 1'b0; ld_addr = 8'h00; ld_wdata = 8'h00;
        wait_clks(3);
        check("reset_busy", {7'd0, busy}, 8'h00);
        check("reset_oe", {7'd0, spi_miso_oe}, 8'h00);
        check("reset_miso", {7'd0, spi_miso}, 8'h00);
        rst = 1'b0;
        wait_clks(10);

        for (int i = 0; i < 256; i++) bd_write(8'(i), 8'($urandom));
        bd_write(8'h00, 8'h10); bd_write(8'h01, 8'h64);
        bd_write(8'h02, 8'h68); bd_write(8'h03, 8'h53);
        bd_write(8'hFF, 8'hAA);
        bd_write(8'h20, 8'h11); bd_write(8'h21, 8'h22);
        bd_write(8'h30, 8'h77); bd_write(8'h40, 8'h33);

        // preload/read and address wrap vectors
        for (int k = 0; k < 3; k++) begin
            spi_read(vecs[k].start, vecs[k].n);
            e = vecs[k].exp;
            for (int j = 0; j < vecs[k].n; j++)
                check($sformatf("vec%0d_byte%0d", k, j), rd_buf[j], e[31-8*j -: 8]);
        end

        // write then read back
        wr_buf[0] = 8'hA5; wr_buf[1] = 8'h5A;
        spi_write(8'h20, 2);
        spi_read(8'h20, 2);
`ifdef SPI_RAM_WRITE_EN
        check("wr_rd_0", rd_buf[0], 8'hA5);
        check("wr_rd_1", rd_buf[1], 8'h5A);
`else
        check("wr_rd_0", rd_buf[0], 8'h11);
        check("wr_rd_1", rd_buf[1], 8'h22);
`endif

        // partial byte is discarded
        spi_select();
        spi_bits(8'h02, 8, rx);
        spi_bits(8'h30, 8, rx);
        spi_bits(8'hFF, 5, rx);
        spi_deselect();
        spi_read(8'h30, 1);
        check("partial_byte", rd_buf[0], 8'h77);

        // unknown opcode keeps MISO quiet
        drive_seen = 1'b0;
        spi_select();
        spi_bits(8'h9F, 8, rx);
        spi_bits(8'hFF, 8, rx);
        spi_bits(8'h5A, 8, rx);
        spi_deselect();
        check("ignore_quiet", {7'd0, drive_seen}, 8'h00);

        // backdoor collision
        spi_select();
        check("busy_selected", {7'd0, busy}, 8'h01);
        bd_write(8'h40, 8'hEE);
        spi_deselect();
        check("busy_deselected", {7'd0, busy}, 8'h00);
        spi_read(8'h40, 1);
        check("bd_blocked", rd_buf[0], 8'h33);
        bd_write(8'h40, 8'hEE);
        spi_read(8'h40, 1);
        check("bd_idle", rd_buf[0], 8'hEE);

        // reset during the second byte of a read
        spi_select();
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
        check("rstmid_byte0", rx, 8'h10);
        check("rstmid_oe_on", {7'd0, spi_miso_oe}, 8'h01);
        spi_bits(8'h00, 3, rx);
        rst = 1'b1;
        wait_clks(1);
        check("rstmid_oe", {7'd0, spi_miso_oe}, 8'h00);
        check("rstmid_miso", {7'd0, spi_miso}, 8'h00);
        check("rstmid_busy", {7'd0, busy}, 8'h00);
        rst = 1'b0;
        spi_cs_n = 1'b1;
        selected = 1'b0;
        wait_clks(10);
        spi_read(8'h01, 1);
        check("rstmid_reread", rd_buf[0], 8'h64);

        // randomized traffic against the reference memory
        for (int it = 0; it < 24; it++) begin
            a = 8'($urandom);
            case ($urandom_range(0, 2))
                0: for (int i = 0; i < 3; i++) bd_write(8'($urandom), 8'($urandom));
                1: begin
                    n = $urandom_range(1, 4);
                    spi_read(a, n);
                    for (int j = 0; j < n; j++)
                        check($sformatf("rand%0d_rd%0d", it, j), rd_buf[j], ref_mem[8'(a + j)]);
                end
                default: begin
                    n = $urandom_range(1, 3);
                    for (int j = 0; j < n; j++) wr_buf[j] = 8'($urandom);
                    spi_write(a, n);
                    spi_read(a, n);
                    for (int j = 0; j < n; j++)
                        check($sformatf("rand%0d_wr%0d", it, j), rd_buf[j], ref_mem[8'(a + j)]);
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
